// File: rtl/onehot_codec.sv
// Registered binary/one-hot/thermometer codec on a valid/ready stream with a
// saturating error counter for malformed one-hot operands.
module onehot_codec #(
  parameter int W   = 4,
  parameter int ECW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          mode,
  input  logic [W-1:0]        in_bin,
  input  logic [(1<<W)-1:0]   in_oh,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [(1<<W)-1:0]   out_oh,
  output logic [W-1:0]        out_bin,
  output logic                out_err,
  output logic [ECW-1:0]      err_count,
  input  logic                err_clr
);

  localparam int N = 1 << W;
  localparam logic [N-1:0]   OH_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [ECW-1:0] CNT_ONE = {{(ECW-1){1'b0}}, 1'b1};
  localparam logic [ECW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    MODE_B2OH = 2'd0,
    MODE_OH2B = 2'd1,
    MODE_B2TH = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  function automatic logic [N-1:0] bin2oh(input logic [W-1:0] b);
    logic [N-1:0] r;
    r    = '0;
    r[b] = 1'b1;
    return r;
  endfunction

  function automatic logic [N-1:0] bin2therm(input logic [W-1:0] b);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i] = (i <= int'(b));
    return r;
  endfunction

  // Two's-complement trick isolates the lowest set bit.
  function automatic logic [N-1:0] oh_lowest(input logic [N-1:0] v);
    return v & (~v + OH_ONE);
  endfunction

  function automatic logic [W-1:0] oh_index(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  function automatic logic oh_bad(input logic [N-1:0] v);
    return (v == '0) || ((v & (v - OH_ONE)) != '0);
  endfunction

  function automatic logic [ECW-1:0] sat_inc(input logic [ECW-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  logic [N-1:0]   oh_p0;
  logic [W-1:0]   bin_p0;
  logic           err_p0;
  logic [N-1:0]   oh_p1;
  logic [W-1:0]   bin_p1;
  logic           err_p1;
  logic           vld_p1;
  logic [ECW-1:0] err_cnt;
  logic           xfer;

  // Stage p0: combinational conversion of the offered operand.
  always_comb begin
    oh_p0  = '0;
    bin_p0 = '0;
    err_p0 = 1'b0;
    case (mode_e'(mode))
      MODE_B2OH: begin
        oh_p0  = bin2oh(in_bin);
        bin_p0 = in_bin;
      end
      MODE_OH2B: begin
        oh_p0  = oh_lowest(in_oh);
        bin_p0 = oh_index(in_oh);
        err_p0 = oh_bad(in_oh);
      end
      MODE_B2TH: begin
        oh_p0  = bin2therm(in_bin);
        bin_p0 = in_bin;
      end
      default: begin
        err_p0 = 1'b1;
      end
    endcase
  end

  assign in_ready = !vld_p1 || out_ready;
  assign xfer     = in_valid && in_ready;

  // Stage p1: output register, loaded only on a transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      oh_p1  <= '0;
      bin_p1 <= '0;
      err_p1 <= 1'b0;
    end else begin
      if (in_ready) vld_p1 <= in_valid;
      if (xfer) begin
        oh_p1  <= oh_p0;
        bin_p1 <= bin_p0;
        err_p1 <= err_p0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (xfer && err_p0) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end

  assign out_valid = vld_p1;
  assign out_oh    = oh_p1;
  assign out_bin   = bin_p1;
  assign out_err   = err_p1;
  assign err_count = err_cnt;

endmodule

// File: tb/tb_onehot_codec.sv
// Scoreboard bench for onehot_codec: W=4 with ECW=8, plus an ECW=2 instance
// sharing the same stimulus for counter saturation.
module tb_onehot_codec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  mode = 2'd0;
  logic [3:0]  in_bin = 4'd0;
  logic [15:0] in_oh = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_oh;
  logic [3:0]  out_bin;
  logic        out_err;
  logic [7:0]  err_count;
  logic        err_clr = 1'b0;

  logic        in_ready2;
  logic        out_valid2;
  logic [15:0] out_oh2;
  logic [3:0]  out_bin2;
  logic        out_err2;
  logic [1:0]  err_count2;

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  typedef struct packed {
    logic [15:0] oh;
    logic [3:0]  bin;
    logic        err;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  onehot_codec #(.W(4), .ECW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .in_bin(in_bin), .in_oh(in_oh), .out_valid(out_valid),
    .out_ready(out_ready), .out_oh(out_oh), .out_bin(out_bin),
    .out_err(out_err), .err_count(err_count), .err_clr(err_clr)
  );

  onehot_codec #(.W(4), .ECW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .mode(mode), .in_bin(in_bin), .in_oh(in_oh), .out_valid(out_valid2),
    .out_ready(out_ready), .out_oh(out_oh2), .out_bin(out_bin2),
    .out_err(out_err2), .err_count(err_count2), .err_clr(err_clr)
  );

  function automatic exp_t model(input logic [1:0] m, input logic [3:0] b,
                                 input logic [15:0] oh);
    exp_t e;
    bit   found;
    e     = '0;
    found = 1'b0;
    case (m)
      2'd0: begin
        for (int i = 0; i < 16; i++) e.oh[i] = (i == int'(b));
        e.bin = b;
      end
      2'd2: begin
        for (int i = 0; i < 16; i++) e.oh[i] = (i <= int'(b));
        e.bin = b;
      end
      2'd1: begin
        for (int i = 0; i < 16; i++) begin
          if (oh[i] && !found) begin
            found   = 1'b1;
            e.bin   = i[3:0];
            e.oh[i] = 1'b1;
          end
        end
        e.err = ($countones(oh) != 1);
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got oh=%h bin=%0d err=%0d, none expected",
                 out_oh, out_bin, out_err);
      end else begin
        e = q.pop_front();
        pops++;
        if ({out_oh, out_bin, out_err} !== e) begin
          bad++;
          $display("FAIL sb_result got oh=%h bin=%0d err=%0d want oh=%h bin=%0d err=%0d",
                   out_oh, out_bin, out_err, e.oh, e.bin, e.err);
        end
      end
    end
  end

  // Offers one transaction, holds it until accepted; returns cycles spent.
  task automatic send(input logic [1:0] m, input logic [3:0] b,
                      input logic [15:0] oh, output int cycles);
    logic acc;
    acc    = 1'b0;
    cycles = 0;
    mode = m; in_bin = b; in_oh = oh; in_valid = 1'b1;
    while (!acc && cycles < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cycles++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout mode=%0d not accepted within %0d cycles", m, cycles);
    end else begin
      q.push_back(model(m, b, oh));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout pending=%0d want 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    total++;
    if (out_oh !== 16'h0) begin bad++; $display("FAIL rst_out_oh got %h want 0000", out_oh); end
    total++;
    if (out_bin !== 4'd0) begin bad++; $display("FAIL rst_out_bin got %0d want 0", out_bin); end
    total++;
    if (out_err !== 1'b0) begin bad++; $display("FAIL rst_out_err got %b want 0", out_err); end
    total++;
    if (err_count !== 8'd0) begin bad++; $display("FAIL rst_err_count got %0d want 0", err_count); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mode0_sweep();
    int c;
    int p0;
    p0 = pops;
    for (int b = 0; b < 16; b++) begin
      send(2'd0, b[3:0], 16'h0, c);
      total++;
      if (c !== 1) begin bad++; $display("FAIL m0_bubble bin=%0d took %0d cycles want 1", b, c); end
    end
    drain();
    total++;
    if (pops - p0 !== 16) begin bad++; $display("FAIL m0_count got %0d results want 16", pops - p0); end
  endtask

  task automatic test_mode2_bounds();
    int c;
    send(2'd2, 4'd0, 16'h0, c);
    send(2'd2, 4'd7, 16'h0, c);
    send(2'd2, 4'd15, 16'h0, c);
    drain();
  endtask

  task automatic test_mode1_check();
    int c;
    send(2'd1, 4'd0, 16'h0400, c);
    send(2'd1, 4'd0, 16'h0000, c);
    send(2'd1, 4'd0, 16'h0A00, c);
    drain();
    total++;
    if (err_count !== 8'd2) begin bad++; $display("FAIL m1_err_count got %0d want 2", err_count); end
  endtask

  task automatic test_backpressure();
    int c;
    int p0;
    p0 = pops;
    send(2'd0, 4'd3, 16'h0, c);
    out_ready = 1'b0;
    mode = 2'd2; in_bin = 4'd5; in_oh = 16'h0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got %b want 0", k, in_ready); end
      total++;
      if ({out_valid, out_oh, out_bin, out_err} !== {1'b1, 16'h0008, 4'd3, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got v=%b oh=%h bin=%0d want v=1 oh=0008 bin=3",
                 k, out_valid, out_oh, out_bin);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(2'd2, 4'd5, 16'h0, c);
    send(2'd1, 4'd0, 16'h0010, c);
    drain();
    total++;
    if (pops - p0 !== 3) begin bad++; $display("FAIL bp_count got %0d results want 3", pops - p0); end
  endtask

  task automatic test_counter_limits();
    int c;
    for (int k = 0; k < 5; k++) send(2'd3, 4'd0, 16'h0, c);
    drain();
    total++;
    if (err_count2 !== 2'd3) begin bad++; $display("FAIL sat_ecw2 got %0d want 3", err_count2); end
    total++;
    if (err_count !== 8'd7) begin bad++; $display("FAIL cnt_ecw8 got %0d want 7", err_count); end
    err_clr = 1'b1;
    send(2'd1, 4'd0, 16'h0000, c);
    err_clr = 1'b0;
    total++;
    if (err_count !== 8'd0) begin bad++; $display("FAIL clr_prio got %0d want 0", err_count); end
    total++;
    if (err_count2 !== 2'd0) begin bad++; $display("FAIL clr_prio_ecw2 got %0d want 0", err_count2); end
    drain();
  endtask

  task automatic test_reset_midstream();
    int c;
    out_ready = 1'b0;
    send(2'd3, 4'd0, 16'h0, c);
    total++;
    if (err_count !== 8'd1) begin bad++; $display("FAIL mid_pre_count got %0d want 1", err_count); end
    mode = 2'd0; in_bin = 4'd9; in_valid = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({out_valid, out_oh, out_bin, out_err, err_count} !== '0) begin
      bad++;
      $display("FAIL mid_reset got v=%b oh=%h bin=%0d err=%b cnt=%0d want all 0",
               out_valid, out_oh, out_bin, out_err, err_count);
    end
    q.delete();
    in_valid = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    send(2'd0, 4'd12, 16'h0, c);
    drain();
  endtask

  initial begin
    test_reset();
    test_mode0_sweep();
    test_mode2_bounds();
    test_mode1_check();
    test_backpressure();
    test_counter_limits();
    test_reset_midstream();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
